// File: rtl/cap_bank_switch_sequencer.sv
// Capacitor-bank switch sequencer.
// Debounces requested serial/parallel code pairs from the frequency
// measurement datapath and applies a committed change with a
// break-before-make sequence: enables low, dead time, load codes,
// settle, enables high. Loss of valid in-range measurements while
// tracking drops both enables.
module cap_bank_switch_sequencer #(
    parameter int CODE_W         = 7,
    parameter int AGREE_N        = 3,
    parameter int DEAD_CYCLES    = 40,
    parameter int SETTLE_CYCLES  = 200,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              meas_valid,
    input  logic              meas_ok,
    input  logic [CODE_W-1:0] code_ser_req,
    input  logic [CODE_W-1:0] code_par_req,
    output logic [CODE_W-1:0] codeSer,
    output logic [CODE_W-1:0] codePar,
    output logic              enableSer,
    output logic              enablePar,
    output logic              busy,
    output logic [15:0]       switch_count
);

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    localparam int SEQ_MAX = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0]       AGREE_MAX   = 4'(AGREE_N);
    localparam logic [SEQ_W-1:0] DEAD_LAST   = SEQ_W'(DEAD_CYCLES - 1);
    localparam logic [SEQ_W-1:0] SETTLE_LAST = SEQ_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

    // Saturating increment for the completed-switch counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value != 16'hFFFF) begin
            sat_inc16 = value + 16'd1;
        end else begin
            sat_inc16 = value;
        end
    endfunction

    logic [1:0]        state_r,    state_s;
    logic [CODE_W-1:0] cand_ser_r, cand_ser_s;
    logic [CODE_W-1:0] cand_par_r, cand_par_s;
    logic [3:0]        agree_r,    agree_s;
    logic [SEQ_W-1:0]  seq_r,      seq_s;
    logic [TO_W-1:0]   to_r,       to_s;
    logic [CODE_W-1:0] code_ser_r, code_ser_s;
    logic [CODE_W-1:0] code_par_r, code_par_s;
    logic              enable_r,   enable_s;
    logic              busy_r,     busy_s;
    logic [15:0]       count_r,    count_s;

    logic meas_acc_s;
    logic req_match_s;

    assign meas_acc_s  = meas_valid & meas_ok;
    assign req_match_s = (code_ser_req == cand_ser_r) && (code_par_req == cand_par_r);

    // Both enables come from one register so they can never disagree.
    assign codeSer      = code_ser_r;
    assign codePar      = code_par_r;
    assign enableSer    = enable_r;
    assign enablePar    = enable_r;
    assign busy         = busy_r;
    assign switch_count = count_r;

    // Next-state logic: candidate debounce, commit, dead/settle timing and timeout.
    always_comb begin
        state_s    = state_r;
        cand_ser_s = cand_ser_r;
        cand_par_s = cand_par_r;
        agree_s    = agree_r;
        seq_s      = seq_r;
        to_s       = to_r;
        code_ser_s = code_ser_r;
        code_par_s = code_par_r;
        enable_s   = enable_r;
        busy_s     = busy_r;
        count_s    = count_r;

        case (state_r)
            ST_OFF, ST_TRACK: begin
                // Candidate tracking; a rejected measurement restarts the agreement run.
                if (meas_valid) begin
                    if (meas_ok) begin
                        if (req_match_s) begin
                            if (agree_r < AGREE_MAX) begin
                                agree_s = agree_r + 4'd1;
                            end else begin
                                agree_s = AGREE_MAX;
                            end
                        end else begin
                            cand_ser_s = code_ser_req;
                            cand_par_s = code_par_req;
                            agree_s    = 4'd1;
                        end
                    end else begin
                        agree_s = 4'd0;
                    end
                end else begin
                    agree_s = agree_r;
                end

                // Loss-of-signal watchdog; an accepted measurement on the expiry edge wins.
                if (state_r == ST_TRACK) begin
                    if (meas_acc_s) begin
                        to_s = {TO_W{1'b0}};
                    end else if (to_r == TO_LAST) begin
                        to_s     = {TO_W{1'b0}};
                        enable_s = 1'b0;
                        agree_s  = 4'd0;
                        state_s  = ST_OFF;
                    end else begin
                        to_s = to_r + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    to_s = {TO_W{1'b0}};
                end

                // Leaving OFF always runs the full sequence; in TRACK only a real change does.
                if ((agree_s == AGREE_MAX) &&
                    ((state_r == ST_OFF) ||
                     ({cand_ser_s, cand_par_s} != {code_ser_r, code_par_r}))) begin
                    state_s  = ST_DEAD;
                    enable_s = 1'b0;
                    busy_s   = 1'b1;
                    seq_s    = {SEQ_W{1'b0}};
                    agree_s  = 4'd0;
                    to_s     = {TO_W{1'b0}};
                end else begin
                    seq_s = seq_r;
                end
            end

            ST_DEAD: begin
                to_s = {TO_W{1'b0}};
                if (seq_r == DEAD_LAST) begin
                    code_ser_s = cand_ser_r;
                    code_par_s = cand_par_r;
                    seq_s      = {SEQ_W{1'b0}};
                    state_s    = ST_SETTLE;
                end else begin
                    seq_s = seq_r + {{(SEQ_W-1){1'b0}}, 1'b1};
                end
            end

            ST_SETTLE: begin
                to_s = {TO_W{1'b0}};
                if (seq_r == SETTLE_LAST) begin
                    enable_s = 1'b1;
                    busy_s   = 1'b0;
                    count_s  = sat_inc16(count_r);
                    seq_s    = {SEQ_W{1'b0}};
                    state_s  = ST_TRACK;
                end else begin
                    seq_s = seq_r + {{(SEQ_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_s  = ST_OFF;
                enable_s = 1'b0;
                busy_s   = 1'b0;
                agree_s  = 4'd0;
                seq_s    = {SEQ_W{1'b0}};
                to_s     = {TO_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset to all-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_OFF;
            cand_ser_r <= {CODE_W{1'b0}};
            cand_par_r <= {CODE_W{1'b0}};
            agree_r    <= 4'd0;
            seq_r      <= {SEQ_W{1'b0}};
            to_r       <= {TO_W{1'b0}};
            code_ser_r <= {CODE_W{1'b0}};
            code_par_r <= {CODE_W{1'b0}};
            enable_r   <= 1'b0;
            busy_r     <= 1'b0;
            count_r    <= 16'd0;
        end else begin
            state_r    <= state_s;
            cand_ser_r <= cand_ser_s;
            cand_par_r <= cand_par_s;
            agree_r    <= agree_s;
            seq_r      <= seq_s;
            to_r       <= to_s;
            code_ser_r <= code_ser_s;
            code_par_r <= code_par_s;
            enable_r   <= enable_s;
            busy_r     <= busy_s;
            count_r    <= count_s;
        end
    end

endmodule

// File: tb/tb_cap_bank_switch_sequencer.sv
// Scoreboard bench for cap_bank_switch_sequencer (AGREE_N=3, DEAD=4,
// SETTLE=8, TIMEOUT=1000). The driver pushes the expected outcome of each
// switch sequence; the monitor pops it when busy rises and checks the
// load timing, the re-enable timing and the final outputs.
module tb_cap_bank_switch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        meas_valid;
    logic        meas_ok;
    logic [6:0]  code_ser_req;
    logic [6:0]  code_par_req;
    logic [6:0]  codeSer;
    logic [6:0]  codePar;
    logic        enableSer;
    logic        enablePar;
    logic        busy;
    logic [15:0] switch_count;

    cap_bank_switch_sequencer #(
        .CODE_W(7), .AGREE_N(3), .DEAD_CYCLES(4), .SETTLE_CYCLES(8), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .reset(reset), .meas_valid(meas_valid), .meas_ok(meas_ok),
        .code_ser_req(code_ser_req), .code_par_req(code_par_req),
        .codeSer(codeSer), .codePar(codePar), .enableSer(enableSer),
        .enablePar(enablePar), .busy(busy), .switch_count(switch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  ser;
        logic [6:0]  par;
        logic [15:0] cnt;
        bit          abort;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [6:0] s, input logic [6:0] p,
                            input logic [15:0] c, input bit ab);
        exp_t e;
        e.ser = s; e.par = p; e.cnt = c; e.abort = ab;
        exp_q.push_back(e);
    endtask

    // One measurement, valid for one cycle; called and returns at a negedge.
    task automatic pulse(input logic [6:0] s, input logic [6:0] p, input logic ok);
        meas_valid   = 1'b1;
        meas_ok      = ok;
        code_ser_req = s;
        code_par_req = p;
        @(negedge clk);
        meas_valid = 1'b0;
        meas_ok    = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("sequence_completes", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: sequence timing and results against the scoreboard queue.
    initial begin
        int         cyc = 0;
        int         rise_cyc = 0;
        logic       busy_q = 1'b0;
        logic       en_q = 1'b0;
        logic [6:0] ser_q = 7'd0;
        logic [6:0] par_q = 7'd0;
        logic [6:0] old_ser = 7'd0;
        logic [6:0] old_par = 7'd0;
        exp_t       cur;
        bit         have_cur = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                cyc++;
                check("enables_equal", 32'(enableSer), 32'(enablePar));
                if (en_q && enableSer)
                    check("codes_stable_while_enabled", 32'({codeSer, codePar}), 32'({ser_q, par_q}));
                if (!busy_q && busy) begin
                    rise_cyc = cyc;
                    old_ser  = ser_q;
                    old_par  = par_q;
                    check("enable_low_at_commit", 32'(enableSer), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_sequence: got busy at cycle %0d expected none", cyc);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (busy && have_cur && !cur.abort) begin
                    check("enable_low_while_busy", 32'(enableSer), 32'd0);
                    if (cyc - rise_cyc == 3)
                        check("codes_before_load", 32'({codeSer, codePar}), 32'({old_ser, old_par}));
                    if (cyc - rise_cyc == 4)
                        check("codes_after_load", 32'({codeSer, codePar}), 32'({cur.ser, cur.par}));
                end
                if (busy_q && !busy && have_cur) begin
                    if (cur.abort) begin
                        check("abort_codes", 32'({codeSer, codePar}), 32'd0);
                        check("abort_enables", 32'({enableSer, enablePar}), 32'd0);
                        check("abort_count", 32'(switch_count), 32'd0);
                    end else begin
                        check("busy_length", 32'(cyc - rise_cyc), 32'd12);
                        check("enable_high_at_done", 32'({enableSer, enablePar}), 32'd3);
                        check("codes_at_done", 32'({codeSer, codePar}), 32'({cur.ser, cur.par}));
                        check("switch_count", 32'(switch_count), 32'(cur.cnt));
                    end
                    have_cur = 1'b0;
                end
                busy_q = busy;
                en_q   = enableSer;
                ser_q  = codeSer;
                par_q  = codePar;
            end
        end
    end

    // Driver: directed scenarios.
    initial begin
        reset        = 1'b1;
        meas_valid   = 1'b0;
        meas_ok      = 1'b0;
        code_ser_req = 7'd0;
        code_par_req = 7'd0;
        repeat (3) @(negedge clk);
        check("reset_codes", 32'({codeSer, codePar}), 32'd0);
        check("reset_enables", 32'({enableSer, enablePar}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(switch_count), 32'd0);
        reset  = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);

        // First lock from OFF.
        push_exp(7'd12, 7'd5, 16'd1, 1'b0);
        repeat (3) pulse(7'd12, 7'd5, 1'b1);
        wait_idle(50);

        // Alternating requests never reach three in a row.
        pulse(7'd12, 7'd5, 1'b1);
        pulse(7'd13, 7'd5, 1'b1);
        pulse(7'd13, 7'd5, 1'b1);
        pulse(7'd12, 7'd5, 1'b1);
        @(negedge clk);
        check("no_commit_busy", 32'(busy), 32'd0);
        check("no_commit_enable", 32'(enableSer), 32'd1);
        check("no_commit_codes", 32'({codeSer, codePar}), 32'({7'd12, 7'd5}));
        check("no_commit_count", 32'(switch_count), 32'd1);

        // Change to (20,9); requests during DEAD must be ignored.
        push_exp(7'd20, 7'd9, 16'd2, 1'b0);
        repeat (3) pulse(7'd20, 7'd9, 1'b1);
        repeat (3) pulse(7'd30, 7'd1, 1'b1);
        wait_idle(50);

        // Two fresh (30,1) requests: agreement restarted, so no commit yet.
        repeat (2) pulse(7'd30, 7'd1, 1'b1);
        check("ignored_in_dead_busy", 32'(busy), 32'd0);
        check("ignored_in_dead_codes", 32'({codeSer, codePar}), 32'({7'd20, 7'd9}));

        // Loss of signal: enables drop 1000 cycles after the last accepted measurement.
        repeat (990) @(negedge clk);
        check("before_timeout_enable", 32'(enableSer), 32'd1);
        repeat (20) @(negedge clk);
        check("after_timeout_enable", 32'({enableSer, enablePar}), 32'd0);
        check("after_timeout_codes", 32'({codeSer, codePar}), 32'({7'd20, 7'd9}));
        check("after_timeout_busy", 32'(busy), 32'd0);

        // Re-lock from OFF on the held codes still runs the full sequence.
        push_exp(7'd20, 7'd9, 16'd3, 1'b0);
        repeat (3) pulse(7'd20, 7'd9, 1'b1);
        wait_idle(50);

        // Reset in the middle of SETTLE aborts the sequence.
        push_exp(7'd7, 7'd7, 16'd0, 1'b1);
        repeat (3) pulse(7'd7, 7'd7, 1'b1);
        repeat (7) @(negedge clk);
        check("in_settle_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_busy", 32'(busy), 32'd0);
        check("reset_mid_enables", 32'({enableSer, enablePar}), 32'd0);
        check("reset_mid_count", 32'(switch_count), 32'd0);
        @(negedge clk);

        // A rejected measurement between agreeing ones restarts the count.
        repeat (2) pulse(7'd5, 7'd3, 1'b1);
        pulse(7'd5, 7'd3, 1'b0);
        repeat (2) pulse(7'd5, 7'd3, 1'b1);
        @(negedge clk);
        check("bad_meas_no_commit", 32'(busy), 32'd0);
        check("bad_meas_enables", 32'(enableSer), 32'd0);
        push_exp(7'd5, 7'd3, 16'd1, 1'b0);
        pulse(7'd5, 7'd3, 1'b1);
        wait_idle(50);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
